// File: rtl/score_bcd_driver.sv
// score_bcd_driver
// Feeds the serial seven-segment display device. A binary score is converted to
// 8 packed BCD digits by a sequential shift-add-3 (double-dabble) engine, one bit
// per clock. Leading-zero blank enables are derived from the result, and a
// one-cycle start pulse launches a serial refresh on every new value and
// periodically thereafter.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   bin_in  in   binary value to display (BIN_WIDTH bits), sampled on load
//   load    in   single-cycle conversion request (queued while busy)
//   busy    out  conversion in progress
//   done    out  one-cycle pulse when hexs/LEs update
//   hexs    out  packed BCD, digit 0 in [3:0]
//   LEs     out  per-digit blank enable, bit i blanks digit i
//   start   out  one-cycle pulse to begin a serial transfer
module score_bcd_driver #(
  parameter int unsigned BIN_WIDTH      = 16,
  parameter int unsigned REFRESH_CYCLES = 1000000,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIN_WIDTH-1:0] bin_in,
  input  logic                 load,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          hexs,
  output logic [7:0]           LEs,
  output logic                 start
);

  localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);
  localparam int unsigned RefW = $clog2(REFRESH_CYCLES);

  localparam logic [CntW-1:0] CntLoad = CntW'(BIN_WIDTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_CYCLES - 1);
  localparam logic [RefW-1:0] RefOne  = RefW'(1);
  localparam logic [7:0]      LesRst  = BLANK_LEADING ? 8'hFE : 8'h00;

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e               r_state;
  logic [BIN_WIDTH-1:0] r_bin;
  logic [31:0]          r_bcd;
  logic [CntW-1:0]      r_cnt;
  logic [BIN_WIDTH-1:0] r_pend_val;
  logic                 r_pend;
  logic [RefW-1:0]      r_ref;
  logic [31:0]          r_hexs;
  logic [7:0]           r_les;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_start;

  logic [27:0] w_bcd_adj;
  logic [31:0] w_bcd_shift;
  logic [7:0]  w_blank;
  logic        w_wrap;
  logic        w_commit_next;

  // Add-3 on digits 0..6. With at most 26 input bits the top digit never
  // reaches 5 before a shift, so it is passed through unadjusted.
  always_comb begin
    w_bcd_adj = '0;
    for (int i = 0; i < 7; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end else begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
      end
    end
    w_bcd_shift = {r_bcd[30:28], w_bcd_adj, r_bin[BIN_WIDTH-1]};
  end

  // Digit i is blanked when it and every more significant digit are zero.
  always_comb begin
    logic v_all_zero;
    w_blank    = '0;
    v_all_zero = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      v_all_zero = v_all_zero & (r_bcd[4*i +: 4] == 4'h0);
      w_blank[i] = v_all_zero;
    end
  end

  assign w_wrap        = (r_ref == RefLast);
  // A COMMIT follows next cycle; its forced start replaces the periodic one so
  // the pulse is never two cycles wide.
  assign w_commit_next = (r_state == StShift) && (r_cnt == CntOne);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_pend_val <= '0;
      r_pend     <= 1'b0;
      r_ref      <= '0;
      r_hexs     <= '0;
      r_les      <= LesRst;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_start    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_start <= (r_state == StCommit) | (w_wrap & ~w_commit_next);

      if (r_state == StCommit || w_wrap) begin
        r_ref <= '0;
      end else begin
        r_ref <= r_ref + RefOne;
      end

      unique case (r_state)
        StIdle: begin
          if (load || r_pend) begin
            r_bin   <= load ? bin_in : r_pend_val;
            r_pend  <= 1'b0;
            r_bcd   <= '0;
            r_cnt   <= CntLoad;
            r_busy  <= 1'b1;
            r_state <= StShift;
          end
        end

        StShift: begin
          r_bcd <= w_bcd_shift;
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt - CntOne;
          if (r_cnt == CntOne) begin
            r_state <= StCommit;
          end
          if (load) begin
            r_pend     <= 1'b1;
            r_pend_val <= bin_in;
          end
        end

        StCommit: begin
          r_hexs <= r_bcd;
          r_les  <= BLANK_LEADING ? w_blank : 8'h00;
          r_done <= 1'b1;
          // A load arriving this cycle is newer than any pending value.
          if (load || r_pend) begin
            r_bin   <= load ? bin_in : r_pend_val;
            r_pend  <= 1'b0;
            r_bcd   <= '0;
            r_cnt   <= CntLoad;
            r_state <= StShift;
          end else begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign hexs  = r_hexs;
  assign LEs   = r_les;
  assign start = r_start;

endmodule

// File: tb/tb_score_bcd_driver.sv
module tb_score_bcd_driver;

  localparam int W = 16;
  localparam int R = 300;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  bin_in = '0;

  logic        busy_a, done_a, start_a, busy_b, done_b, start_b;
  logic [31:0] hexs_a, hexs_b;
  logic [7:0]  les_a, les_b;

  int n_checks = 0;
  int n_fail   = 0;
  bit saw200   = 1'b0;

  score_bcd_driver #(.BIN_WIDTH(W), .REFRESH_CYCLES(R), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load), .busy(busy_a),
    .done(done_a), .hexs(hexs_a), .LEs(les_a), .start(start_a)
  );

  score_bcd_driver #(.BIN_WIDTH(W), .REFRESH_CYCLES(R), .BLANK_LEADING(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load), .busy(busy_b),
    .done(done_b), .hexs(hexs_b), .LEs(les_b), .start(start_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] to_bcd(int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Digits i..7 all zero exactly when the value is below 10**i.
  function automatic logic [7:0] blank_of(int unsigned v);
    logic [7:0] m;
    int unsigned p;
    m = '0;
    p = 10;
    for (int i = 1; i < 8; i++) begin
      m[i] = (v < p);
      p = p * 10;
    end
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks each conversion by the edge on which it commits.
  longint      e = 0;
  bit          m_active = 0, m_pend = 0, m_done = 0, m_start = 0;
  int unsigned m_val = 0, m_pend_val = 0;
  longint      m_commit = 0;
  int          m_rc = 0;
  logic [31:0] m_hexs = '0;
  logic [7:0]  m_les = 8'hFE;

  always @(posedge clk) begin
    bit commit_now;
    commit_now = 1'b0;
    if (!rst_n) begin
      m_active = 0; m_pend = 0; m_done = 0; m_start = 0; m_rc = 0;
      m_hexs = '0; m_les = 8'hFE;
    end else begin
      m_done = 0;
      if (m_active && e == m_commit) begin
        commit_now = 1'b1;
        m_hexs = to_bcd(m_val);
        m_les  = blank_of(m_val);
        m_done = 1;
        if (load) begin
          m_val = bin_in; m_commit = e + W + 1; m_pend = 0;
        end else if (m_pend) begin
          m_val = m_pend_val; m_commit = e + W + 1; m_pend = 0;
        end else begin
          m_active = 0;
        end
      end else if (m_active) begin
        if (load) begin
          m_pend = 1; m_pend_val = bin_in;
        end
      end else if (load) begin
        m_active = 1; m_val = bin_in; m_commit = e + W + 1;
      end
      if (commit_now) begin
        m_rc = 0; m_start = 1;
      end else if (m_rc == R - 1) begin
        m_rc = 0;
        m_start = !(m_active && m_commit == e + 1);
      end else begin
        m_rc++; m_start = 0;
      end
    end
    e++;
    #1;
    check("hexs_a", hexs_a, m_hexs);
    check("les_a", {24'h0, les_a}, {24'h0, m_les});
    check("busy_a", {31'h0, busy_a}, {31'h0, m_active});
    check("done_a", {31'h0, done_a}, {31'h0, m_done});
    check("start_a", {31'h0, start_a}, {31'h0, m_start});
    check("hexs_b", hexs_b, m_hexs);
    check("les_b", {24'h0, les_b}, 32'h0);
    check("busy_b", {31'h0, busy_b}, {31'h0, m_active});
    check("done_b", {31'h0, done_b}, {31'h0, m_done});
    check("start_b", {31'h0, start_b}, {31'h0, m_start});
    if (hexs_a == 32'h0000_0200) saw200 = 1'b1;
  end

  task automatic do_load(input int unsigned v);
    @(negedge clk);
    bin_in = W'(v);
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done_a) begin
        k = i;
        break;
      end
    end
    if (k == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: no done within 60 cycles (t=%0t)", $time);
    end
  endtask

  task automatic wait_start(output int k);
    k = 0;
    for (int i = 1; i <= 700; i++) begin
      @(posedge clk);
      #1;
      if (start_a) begin
        k = i;
        break;
      end
    end
    if (k == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_start: no start within 700 cycles (t=%0t)", $time);
    end
  endtask

  initial begin
    int k;
    bit seen_done;
    repeat (3) @(negedge clk);
    check("rst_hexs", hexs_a, 32'h0);
    check("rst_les_a", {24'h0, les_a}, 32'hFE);
    rst_n = 1'b1;

    do_load(1234);
    wait_done(k);
    check("lat_1234", k, 17);
    check("hexs_1234", hexs_a, 32'h0000_1234);
    check("les_1234", {24'h0, les_a}, 32'hF0);
    check("start_1234", {31'h0, start_a}, 32'h1);
    @(posedge clk); #1;
    check("done_one_cycle", {31'h0, done_a}, 32'h0);

    do_load(0);
    wait_done(k);
    check("hexs_0", hexs_a, 32'h0);
    check("les_0", {24'h0, les_a}, 32'hFE);

    do_load(65535);
    wait_done(k);
    check("hexs_65535", hexs_a, 32'h0006_5535);
    check("les_65535", {24'h0, les_a}, 32'hE0);

    do_load(7);
    wait_done(k);
    check("hexs_b_7", hexs_b, 32'h0000_0007);
    check("les_b_7", {24'h0, les_b}, 32'h00);

    // Pending overwrite: 200 is replaced by 300 before it can start.
    do_load(100);
    repeat (4) @(negedge clk);
    do_load(200);
    repeat (2) @(negedge clk);
    do_load(300);
    wait_done(k);
    check("hexs_100", hexs_a, 32'h0000_0100);
    check("busy_held", {31'h0, busy_a}, 32'h1);
    wait_done(k);
    check("lat_pending", k, 17);
    check("hexs_300", hexs_a, 32'h0000_0300);
    check("never_200", {31'h0, saw200}, 32'h0);

    // Periodic refresh with no loads.
    wait_start(k);
    wait_start(k);
    check("refresh_period", k, R);

    // Commit at counter 150 forces start, then the period restarts from it.
    repeat (132) @(negedge clk);
    do_load(5);
    wait_start(k);
    check("commit_start_lat", k, 17);
    check("commit_done", {31'h0, done_a}, 32'h1);
    wait_start(k);
    check("refresh_after_commit", k, R);

    // Reset in the middle of a conversion.
    do_load(9999);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rstm_hexs", hexs_a, 32'h0);
    check("rstm_les_a", {24'h0, les_a}, 32'hFE);
    check("rstm_les_b", {24'h0, les_b}, 32'h00);
    check("rstm_ctl", {29'h0, busy_a, done_a, start_a}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done_a) seen_done = 1'b1;
    end
    check("rstm_no_done", {31'h0, seen_done}, 32'h0);
    do_load(42);
    wait_done(k);
    check("hexs_42", hexs_a, 32'h0000_0042);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) bin_in = W'($urandom_range(0, 99));
      else                           bin_in = W'($urandom_range(0, 65535));
    end
    @(negedge clk);
    load = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
